// File: rtl/multiplier_sequencer.sv
// Control FSM for the sequential shift-and-add multiplier datapath.
// Emits clear/load/add/shift strobes and a start/done handshake.
module multiplier_sequencer #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 multiplier_lsb,
    output logic                 clear_regs,
    output logic                 load_operands,
    output logic                 add_en,
    output logic                 shift_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] step_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WORD_LENGTH - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clear_regs    = 1'b0;
        load_operands = 1'b0;
        add_en        = 1'b0;
        shift_en      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                clear_regs = 1'b1;
                busy       = 1'b1;
                state_d    = abort ? IDLE : LOAD;
            end
            LOAD: begin
                load_operands = 1'b1;
                busy          = 1'b1;
                cnt_d         = '0;
                if (abort) begin
                    clear_regs = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                add_en   = multiplier_lsb;
                // Abort outranks the final-step exit so no done escapes.
                if (abort) begin
                    clear_regs = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign step_count = cnt_q;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Directed self-checking bench for multiplier_sequencer.
// Output bundle: {clear,load,add,shift,busy,done,step[3:0]}.
module tb_multiplier_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       multiplier_lsb;
    logic       clear_regs;
    logic       load_operands;
    logic       add_en;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [3:0] step_count;
    logic [9:0] outs;

    int checks;
    int errors;

    multiplier_sequencer #(
        .WORD_LENGTH(8),
        .CNT_WIDTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .multiplier_lsb(multiplier_lsb),
        .clear_regs    (clear_regs),
        .load_operands (load_operands),
        .add_en        (add_en),
        .shift_en      (shift_en),
        .busy          (busy),
        .done          (done),
        .step_count    (step_count)
    );

    assign outs = {clear_regs, load_operands, add_en, shift_en,
                   busy, done, step_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic c, input logic l,
                                      input logic a, input logic s,
                                      input logic b, input logic d,
                                      input logic [3:0] st);
        return {c, l, a, s, b, d, st};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, 32'(outs), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] pat;
    int         d_at[3];
    int         n_done;
    int         n_busy;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        multiplier_lsb = 1'b0;
        pat = 8'b1000_1101;

        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'd0);
        reset = 1'b1;
        nxt();
        expect_outs("idle0", '0);

        // Nominal run with lsb pattern 1,0,1,1,0,0,0,1
        nxt();
        start = 1'b1;
        nxt();
        start = 1'b0;
        expect_outs("n_clear", mk(1, 0, 0, 0, 1, 0, 4'd0));
        nxt();
        expect_outs("n_load", mk(0, 1, 0, 0, 1, 0, 4'd0));
        for (int i = 0; i < 8; i++) begin
            nxt();
            multiplier_lsb = pat[i];
            expect_outs($sformatf("n_comp%0d", i),
                        mk(0, 0, pat[i], 1, 1, 0, 4'(i)));
        end
        nxt();
        multiplier_lsb = 1'b0;
        expect_outs("n_done", mk(0, 0, 0, 0, 1, 1, 4'd0));
        nxt();
        expect_outs("n_idle", '0);

        // Abort on the last compute step
        start = 1'b1;
        nxt();
        start = 1'b0;
        expect_outs("al_clear", mk(1, 0, 0, 0, 1, 0, 4'd0));
        nxt();
        expect_outs("al_load", mk(0, 1, 0, 0, 1, 0, 4'd0));
        for (int i = 0; i < 8; i++) begin
            nxt();
            multiplier_lsb = 1'b1;
            abort = (i == 7);
            expect_outs($sformatf("al_comp%0d", i),
                        mk(i == 7, 0, 1, 1, 1, 0, 4'(i)));
        end
        nxt();
        abort = 1'b0;
        multiplier_lsb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_outs($sformatf("al_after%0d", i), '0);
            nxt();
        end

        // Abort during LOAD
        start = 1'b1;
        nxt();
        start = 1'b0;
        expect_outs("ald_clear", mk(1, 0, 0, 0, 1, 0, 4'd0));
        nxt();
        abort = 1'b1;
        expect_outs("ald_load", mk(1, 1, 0, 0, 1, 0, 4'd0));
        nxt();
        abort = 1'b0;
        expect_outs("ald_busy0", '0);
        for (int i = 0; i < 10; i++) begin
            nxt();
            expect_outs($sformatf("ald_idle%0d", i), '0);
        end

        // Asynchronous reset at compute step 3
        nxt();
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        for (int i = 0; i < 4; i++) nxt();
        expect_outs("rs_step3", mk(0, 0, 0, 1, 1, 0, 4'd3));
        #1;
        reset = 1'b0;
        #1;
        check("rs_async", 32'(outs), 32'd0);
        nxt();
        check("rs_held", 32'(outs), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            expect_outs($sformatf("rs_idle%0d", i), '0);
        end

        // Start held high: done every 12 cycles
        nxt();
        start = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int c = 1; c <= 40; c++) begin
            nxt();
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                if (n_done < 3) d_at[n_done] = c;
                n_done++;
            end
        end
        check("sh_ndone", 32'(n_done), 32'd3);
        check("sh_first", 32'(d_at[0]), 32'd11);
        check("sh_gap1", 32'(d_at[1] - d_at[0]), 32'd12);
        check("sh_gap2", 32'(d_at[2] - d_at[1]), 32'd12);
        check("sh_busy", 32'(n_busy), 32'd37);
        start = 1'b0;
        repeat (12) nxt();
        expect_outs("sh_drain", '0);

        // Gating and start+abort together in IDLE
        nxt();
        start = 1'b1;
        abort = 1'b1;
        multiplier_lsb = 1'b1;
        expect_outs("g_idle", '0);
        nxt();
        start = 1'b0;
        abort = 1'b0;
        expect_outs("g_clear", mk(1, 0, 0, 0, 1, 0, 4'd0));
        nxt();
        expect_outs("g_load", mk(0, 1, 0, 0, 1, 0, 4'd0));
        for (int i = 0; i < 8; i++) begin
            nxt();
            expect_outs($sformatf("g_comp%0d", i),
                        mk(0, 0, 1, 1, 1, 0, 4'(i)));
        end
        nxt();
        expect_outs("g_done", mk(0, 0, 0, 0, 1, 1, 4'd0));
        nxt();
        expect_outs("g_idle2", '0);
        multiplier_lsb = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
